// File: rtl/act_feeder_pkg.sv
// Shared types and default widths for the activation row feeder.
package act_feeder_pkg;

  localparam int DEF_N_ROW    = 3;
  localparam int DEF_WID_ACT  = 16;
  localparam int DEF_WID_INST = 14;
  localparam int DEF_WID_LEN  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INST   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  // Row index width; never collapses below one bit.
  function automatic int row_width(input int n_row);
    return (n_row > 1) ? $clog2(n_row) : 1;
  endfunction

endpackage

// File: rtl/act_skid_buf.sv
// Two-entry valid/ready skid buffer. out_vld, out_data and in_rdy all come
// straight from flops, so neither side sees a combinational path through it.
module act_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk_l,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic             empty
);

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_rdy_q;
  logic             in_fire, out_fire;

  assign in_fire  = in_vld && in_rdy_q;
  assign out_fire = out_vld_q && out_rdy;

  // Next-state: drain output (refilling from skid), then place any new beat
  // in the output slot if free, otherwise park it in the skid slot.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (out_fire) begin
      if (skid_vld_q) begin
        out_data_d = skid_data_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = 1'b0;
      end
    end
    if (in_fire) begin
      if (!out_vld_d) begin
        out_vld_d  = 1'b1;
        out_data_d = in_data;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = in_data;
      end
    end
  end

  // Storage registers; ready is registered as "skid slot will be free".
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      in_rdy_q    <= 1'b1;
    end else begin
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      in_rdy_q    <= !skid_vld_d;
    end
  end

  assign in_rdy   = in_rdy_q;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign empty    = !out_vld_q && !skid_vld_q;

endmodule

// File: rtl/act_row_feeder.sv
// Activation row feeder: takes a command (row, length, instruction), pulses
// the instruction to the target row, then streams upstream beats to that row
// through a skid buffer. Macro ACT_FEEDER_STATUS_WAIT_EN makes DONE wait for
// the target row's status_sblk before returning to IDLE.
module act_row_feeder
  import act_feeder_pkg::*;
#(
  parameter int N_ROW    = DEF_N_ROW,
  parameter int WID_ACT  = DEF_WID_ACT,
  parameter int WID_INST = DEF_WID_INST,
  parameter int WID_LEN  = DEF_WID_LEN,
  parameter int WID_ROW  = row_width(N_ROW)
) (
  input  logic                        clk_l,
  input  logic                        rst_n,
  input  logic [WID_ROW-1:0]          cmd_row,
  input  logic [WID_LEN-1:0]          cmd_len,
  input  logic [WID_INST-1:0]         cmd_inst,
  input  logic                        cmd_vld,
  output logic                        cmd_rdy,
  input  logic [2*WID_ACT-1:0]        up_data,
  input  logic                        up_vld,
  output logic                        up_rdy,
  output logic [2*WID_ACT*N_ROW-1:0]  act_data_in,
  output logic [N_ROW-1:0]            act_data_in_vld,
  input  logic [N_ROW-1:0]            act_data_in_req,
  output logic [WID_INST*N_ROW-1:0]   inst_data,
  output logic [N_ROW-1:0]            inst_en,
  input  logic [N_ROW-1:0]            status_sblk,
  output logic                        busy
);

  localparam int WID_BEAT = 2 * WID_ACT;

  feeder_state_e        state_q, state_d;
  logic [WID_ROW-1:0]   row_q, row_d;
  logic [WID_LEN-1:0]   cnt_q, cnt_d;
  logic [WID_INST-1:0]  inst_q, inst_d;

  logic                 row_ok;
  logic                 up_fire;
  logic                 sb_in_rdy;
  logic                 sb_out_vld;
  logic                 sb_out_rdy;
  logic                 sb_empty;
  logic [WID_BEAT-1:0]  sb_out_data;
  logic                 status_done;

  assign row_ok  = 32'(cmd_row) < 32'(N_ROW);
  assign cmd_rdy = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign up_rdy  = (state_q == STREAM) && (cnt_q != '0) && sb_in_rdy;
  assign up_fire = up_vld && up_rdy;
  // Downstream ready is taken only from the selected row.
  assign sb_out_rdy = (state_q == STREAM) && act_data_in_req[row_q];

`ifdef ACT_FEEDER_STATUS_WAIT_EN
  assign status_done = status_sblk[row_q];
`else
  logic unused_status;
  assign unused_status = ^status_sblk;
  assign status_done   = 1'b1;
`endif

  act_skid_buf #(
    .WIDTH (WID_BEAT)
  ) u_skid (
    .clk_l    (clk_l),
    .rst_n    (rst_n),
    .in_vld   (up_fire),
    .in_data  (up_data),
    .in_rdy   (sb_in_rdy),
    .out_vld  (sb_out_vld),
    .out_data (sb_out_data),
    .out_rdy  (sb_out_rdy),
    .empty    (sb_empty)
  );

  // Next-state and command latch; out-of-range rows are accepted and dropped.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_vld && row_ok) begin
          row_d   = cmd_row;
          cnt_d   = cmd_len;
          inst_d  = cmd_inst;
          state_d = INST;
        end
      end
      INST: begin
        state_d = (cnt_q != '0) ? STREAM : DONE;
      end
      STREAM: begin
        if (up_fire) begin
          cnt_d = cnt_q - WID_LEN'(1);
        end
        if ((cnt_q == '0) && sb_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (status_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and command registers.
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
    end
  end

  // Row demux: only the latched row sees the instruction and beat; the others
  // are held at zero. Everything here is selected from registered sources.
  always_comb begin
    act_data_in     = '0;
    act_data_in_vld = '0;
    inst_data       = '0;
    inst_en         = '0;
    for (int unsigned r = 0; r < N_ROW; r++) begin
      if (WID_ROW'(r) == row_q) begin
        if (state_q == INST) begin
          inst_en[r]                          = 1'b1;
          inst_data[r*WID_INST +: WID_INST]   = inst_q;
        end
        if (state_q == STREAM) begin
          act_data_in_vld[r]                  = sb_out_vld;
          act_data_in[r*WID_BEAT +: WID_BEAT] = sb_out_data;
        end
      end
    end
  end

endmodule

// File: doc/act_row_feeder.md
ACT_ROW_FEEDER -- requirements
Module: act_row_feeder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_ROW, 3, number of superblock rows driven.
- WID_ACT, 16, activation element width; one beat is 2*WID_ACT.
- WID_INST, 14, per-row instruction width.
- WID_LEN, 16, command beat-count width.
- WID_ROW, max(1,$clog2(N_ROW)), row index width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_l, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- cmd_row, in, WID_ROW, target row.
- cmd_len, in, WID_LEN, beats to stream.
- cmd_inst, in, WID_INST, instruction for the target row.
- cmd_vld, in, 1, command valid.
- cmd_rdy, out, 1, command accepted when cmd_vld&&cmd_rdy.
- up_data, in, 2*WID_ACT, upstream activation beat.
- up_vld, in, 1, upstream beat valid.
- up_rdy, out, 1, upstream beat accepted when up_vld&&up_rdy.
- act_data_in, out, 2*WID_ACT*N_ROW, per-row beat; row r occupies slice [r*2*WID_ACT +: 2*WID_ACT].
- act_data_in_vld, out, N_ROW, per-row beat valid.
- act_data_in_req, in, N_ROW, per-row ready; a transfer occurs when vld[r]&&req[r].
- inst_data, out, WID_INST*N_ROW, per-row instruction slice.
- inst_en, out, N_ROW, one-cycle instruction strobe.
- status_sblk, in, N_ROW, per-row done status.
- busy, out, 1, high whenever state!=IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, INST, STREAM and DONE.
REQ-004 In IDLE, cmd_rdy SHALL be 1; on cmd_vld it SHALL latch row, len and inst, then go to INST.
REQ-005 A cmd_row>=N_ROW SHALL be accepted and discarded, and the FSM SHALL stay in IDLE.
REQ-006 INST SHALL last exactly one cycle with inst_en[row]=1 and inst_data slice[row]=inst.
- All other inst_en bits SHALL be 0, and all other inst_data slices SHALL be 0.
- Next state SHALL be STREAM if len!=0, otherwise DONE.
REQ-007 In STREAM, up_rdy SHALL equal the skid buffer's in_rdy only while the remaining count is nonzero.
- Each accepted upstream beat SHALL decrement the count by 1.
REQ-008 The skid buffer output SHALL drive only row[row].
- act_data_in_vld[row] SHALL equal the buffer out_vld.
- Non-selected vld bits SHALL be 0 and non-selected data slices SHALL be 0.
- Outputs SHALL be registered.
REQ-009 Latency SHALL be 1 cycle from an upstream accept to act_data_in_vld.
- Full throughput SHALL be 1 beat/cycle while req stays high.
- A req deassertion SHALL hold the data stable, lose no beat and duplicate no beat.
REQ-010 STREAM->DONE SHALL occur when count==0 and the skid buffer is empty.
REQ-011 DONE->IDLE SHALL follow the behaviour defined in REQ-015.
REQ-012 A req[r] for a non-selected row SHALL be ignored; a vld SHALL never be asserted on an unselected row.

Reset
REQ-013 On rst_n low, asynchronously:
- state SHALL be IDLE, count SHALL be 0 and the skid buffer SHALL be empty.
- All vld, inst_en, data and inst_data outputs SHALL be 0, busy SHALL be 0 and up_rdy SHALL be 0.
- cmd_rdy SHALL be 1 once rst_n is high.
REQ-014 A reset in mid-stream SHALL drop all in-flight beats, with no partial completion on release.

Configuration
REQ-015 The behaviour of macro ACT_FEEDER_STATUS_WAIT_EN SHALL be as follows.
- When defined, DONE SHALL hold until status_sblk[row]==1, then go to IDLE.
- When undefined, DONE SHALL go to IDLE after one cycle, and status_sblk SHALL be unused.

Structure
REQ-016 Package act_feeder_pkg SHALL hold the FSM state enum and the default width constants.
REQ-017 A sub-module act_skid_buf SHALL be used.
- It SHALL be a 2-entry valid/ready skid buffer, 2*WID_ACT wide, on clk_l/rst_n.
- It SHALL have registered out_vld/out_data and registered in_rdy.

Verification
REQ-018 The bench SHALL cover these scenarios.
- cmd row=1, len=4, inst=0x155, req[1] high -> inst_en=3'b010 for 1 cycle, then 4 beats on row 1 in 4 consecutive cycles, busy low 2 cycles after the last beat.
- len=0, row=2 -> single inst_en[2] pulse, no vld, back in IDLE.
- row=0, len=8, req[0] toggled 1010... -> exactly 8 beats, in order, data held while req=0.
- row=3 -> cmd accepted, no inst_en, no vld, busy stays 0.
- rst_n pulsed after 3 of 6 beats -> all outputs 0 immediately; a new cmd after release behaves normally.
- With ACT_FEEDER_STATUS_WAIT_EN, status_sblk[1] raised 10 cycles after the last beat -> cmd_rdy stays low until the cycle after status; without the macro, it returns after 1 cycle.
